elevador_ctrl_n: RTL

ELEVADOR_CTRL_N -- requirements
Module: elevador_ctrl_n

---
 rtl/elevador_pkg.sv | 8 +
 rtl/elevador_timer.sv | 16 +
 rtl/elevador_ctrl_n.sv | 133 +++++++++++++
 3 files changed

// File: rtl/elevador_pkg.sv
// elevador_pkg: state encoding and default parameters shared by the elevator controller.
package elevador_pkg;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR, ERRO} state_t;
    localparam int DEF_NUM_FLOORS  = 4;
    localparam int DEF_MOVE_CYCLES = 16;
    localparam int DEF_DOOR_CYCLES = 8;
    localparam int TMR_W           = 16;
endpackage

// File: rtl/elevador_timer.sv
// elevador_timer: loadable down-counter; o_done is high while the count sits at zero.
module elevador_timer import elevador_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_val,
    output logic             o_done
);
    logic [TMR_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_done = r_cnt == '0;
endmodule

// File: rtl/elevador_ctrl_n.sv
// elevador_ctrl_n: N-floor elevator controller (IDLE/MOVE/DOOR/ERRO) with latched calls.
// Define ELEVADOR_EMERG_EN to add the emerg input (clear calls, stop at next floor, hold door).
module elevador_ctrl_n import elevador_pkg::*; #(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FLOORS-1:0]         call_req,
    input  logic                          PA,
`ifdef ELEVADOR_EMERG_EN
    input  logic                          emerg,
`endif
    output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
    output logic                          moving,
    output logic                          dir_up,
    output logic                          door_open,
    output logic [NUM_FLOORS-1:0]         pending,
    output logic                          Erro
);
    localparam int FW = $clog2(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS-1);
    localparam logic [TMR_W-1:0] MV_LD = TMR_W'(MOVE_CYCLES-1);
    localparam logic [TMR_W-1:0] DR_LD = TMR_W'(DOOR_CYCLES-1);

    state_t                r_state;
    logic [FW-1:0]         r_cur;
    logic                  r_moving, r_dir, r_door, r_erro;
    logic [NUM_FLOORS-1:0] r_pend;
    logic [FW-1:0]         w_nf;
    logic [NUM_FLOORS-1:0] w_oh_cur, w_oh_nf, w_keep, w_clr, w_pend_nx;
    logic w_emg, w_here, w_hit, w_arrive, w_ld_mv, w_ld_dr, w_rev, w_mv_done, w_dr_done;
    logic w_ahead_c, w_behind_c, w_ahead_n, w_behind_n;

    // Mask of floors strictly above (up=1) or below (up=0) floor f.
    function automatic logic [NUM_FLOORS-1:0] f_side(input logic [FW-1:0] f, input logic up);
        for (int i = 0; i < NUM_FLOORS; i++) f_side[i] = up ? (i > int'(f)) : (i < int'(f));
    endfunction

`ifdef ELEVADOR_EMERG_EN
    logic r_emg;
    assign w_emg = emerg | r_emg;
    always_ff @(posedge clk) begin
        if (rst) r_emg <= 1'b0;
        else r_emg <= r_state == MOVE && !PA && !w_mv_done && w_emg;
    end
`else
    assign w_emg = 1'b0;
`endif

    assign w_nf       = r_dir ? (r_cur == TOP ? r_cur : r_cur + 1'b1) : (r_cur == '0 ? r_cur : r_cur - 1'b1);
    assign w_oh_cur   = ONE << r_cur;
    assign w_oh_nf    = ONE << w_nf;
    assign w_ahead_c  = |(r_pend & f_side(r_cur, r_dir));
    assign w_behind_c = |(r_pend & f_side(r_cur, !r_dir));
    assign w_ahead_n  = |(r_pend & f_side(w_nf, r_dir));
    assign w_behind_n = |(r_pend & f_side(w_nf, !r_dir));
    assign w_here     = call_req[r_cur] | r_pend[r_cur] | w_emg;
    assign w_hit      = r_pend[w_nf] | w_emg;
    assign w_arrive   = r_state == MOVE && !PA && w_mv_done;
    assign w_ld_dr    = (r_state == IDLE && w_here) || (w_arrive && w_hit) ||
                        (r_state == DOOR && (call_req[r_cur] || w_emg || (w_dr_done && PA)));
    assign w_ld_mv    = (r_state == IDLE && !w_here && (w_ahead_c || w_behind_c)) ||
                        (w_arrive && !w_hit && (w_ahead_n || w_behind_n));
    assign w_rev      = (r_state == IDLE && !w_here && !w_ahead_c && w_behind_c) ||
                        (w_arrive && !w_hit && !w_ahead_n && w_behind_n);
    // A call for the floor the cabin is standing at reopens the door instead of latching.
    assign w_keep     = r_state == MOVE ? '1 : ~w_oh_cur;
    assign w_clr      = (r_state == IDLE && w_here) ? w_oh_cur : (w_arrive && w_hit) ? w_oh_nf : '0;
    assign w_pend_nx  = w_emg ? '0 : (r_pend | (call_req & w_keep)) & ~w_clr;

    elevador_timer u_mv (.clk(clk), .rst(rst), .i_load(w_ld_mv), .i_val(MV_LD), .o_done(w_mv_done));
    elevador_timer u_dr (.clk(clk), .rst(rst), .i_load(w_ld_dr), .i_val(DR_LD), .o_done(w_dr_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_moving <= 1'b0;
            r_dir    <= 1'b1;
            r_door   <= 1'b0;
            r_pend   <= '0;
            r_erro   <= 1'b0;
        end else begin
            if (r_state != ERRO && !(r_state == MOVE && PA)) r_pend <= w_pend_nx;
            if (w_rev) r_dir <= ~r_dir;
            case (r_state)
                IDLE: begin
                    if (w_ld_dr) begin
                        r_state <= DOOR;
                        r_door  <= 1'b1;
                    end else if (w_ld_mv) begin
                        r_state  <= MOVE;
                        r_moving <= 1'b1;
                    end
                end
                MOVE: begin
                    if (PA) begin
                        r_state  <= ERRO;
                        r_erro   <= 1'b1;
                        r_moving <= 1'b0;
                    end else if (w_mv_done) begin
                        r_cur <= w_nf;
                        if (w_ld_dr) begin
                            r_state  <= DOOR;
                            r_door   <= 1'b1;
                            r_moving <= 1'b0;
                        end else if (!w_ld_mv) begin
                            r_state  <= IDLE;
                            r_moving <= 1'b0;
                        end
                    end
                end
                DOOR: begin
                    if (w_dr_done && !w_ld_dr) begin
                        r_state <= IDLE;
                        r_door  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cur_floor = r_cur;
    assign moving    = r_moving;
    assign dir_up    = r_dir;
    assign door_open = r_door;
    assign pending   = r_pend;
    assign Erro      = r_erro;
endmodule
